// File: rtl/tt_um_c13_seq_divider.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor,
// one quotient bit per clock under a start/busy/done handshake.
module tt_um_c13_seq_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        s1_q, s2_q, s3_q, sp_q;
  logic [7:0]  a_q, a_d;
  logic [3:0]  d_q, d_d;
  logic [3:0]  p_q, p_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;
  logic [7:0]  qo_q, qo_d;
  logic [3:0]  ro_q, ro_d;
  logic [4:0]  t_w, diff_w;
  logic        ge_w;
  logic        unused_w;

  assign unused_w = &{1'b0, ena, uio_in[7:6]};

  // trial subtraction of the divisor from the shifted partial remainder
  assign t_w    = {p_q, a_q[7]};
  assign ge_w   = t_w >= {1'b0, d_q};
  assign diff_w = t_w - {1'b0, d_q};

  // start synchroniser, edge detector and registered one-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      sp_q <= 1'b0;
    end else begin
      s1_q <= uio_in[4];
      s2_q <= s1_q;
      s3_q <= s2_q;
      sp_q <= s2_q & ~s3_q;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= 8'h00;
      d_q     <= 4'h0;
      p_q     <= 4'h0;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      qo_q    <= 8'h00;
      ro_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      d_q     <= d_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      qo_q    <= qo_d;
      ro_q    <= ro_d;
    end
  end

  // next-state: capture, one restoring step per cycle, completion
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    qo_d    = qo_q;
    ro_d    = ro_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (sp_q) begin
          a_d     = ui_in;
          d_d     = uio_in[3:0];
          p_d     = 4'h0;
          cnt_d   = 3'd0;
          done_d  = 1'b0;
          dbz_d   = 1'b0;
          busy_d  = |uio_in[3:0];
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (d_q == 4'h0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          dbz_d   = 1'b1;
          qo_d    = 8'hFF;
          ro_d    = 4'h0;
        end else begin
          if (ge_w) begin
            p_d = diff_w[3:0];
            a_d = {a_q[6:0], 1'b1};
          end else begin
            p_d = t_w[3:0];
            a_d = {a_q[6:0], 1'b0};
          end
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            qo_d    = a_d;
            ro_d    = p_d;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign uo_out  = uio_in[5] ? {dbz_q, 3'b000, ro_q} : qo_q;
  assign uio_out = {done_q, busy_q, 6'b00_0000};
  assign uio_oe  = 8'b1100_0000;

endmodule

// File: tb/tb_tt_um_c13_seq_divider.sv
// Bench for the sequential divider: timeline-based
// reference model, per-cycle compare, literal pins.
module tb_tt_um_c13_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  tt_um_c13_seq_divider dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int n;
    int d;
  } op_t;

  op_t ops[$];
  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;
  int  busy_cnt = 0;

  function automatic int lat(int d);
    return (d == 0) ? 1 : 8;
  endfunction

  function automatic void res(input op_t o, output logic [7:0] q,
                              output logic [3:0] r, output logic z);
    if (o.d == 0) begin
      q = 8'hFF; r = 4'h0; z = 1'b1;
    end else begin
      q = 8'(o.n / o.d); r = 4'(o.n % o.d); z = 1'b0;
    end
  endfunction

  function automatic void expect_out(output logic [7:0] uo,
                                     output logic [7:0] uio);
    logic [7:0] q;
    logic [3:0] r;
    logic z, bsy, dn;
    int idx;
    q = 8'h00; r = 4'h0; z = 1'b0; bsy = 1'b0; dn = 1'b0;
    idx = -1;
    for (int i = 0; i < ops.size(); i++)
      if (ops[i].c <= cyc) idx = i;
    if (idx >= 0) begin
      if (cyc < ops[idx].c + lat(ops[idx].d)) begin
        bsy = (ops[idx].d != 0);
        if (idx > 0) res(ops[idx-1], q, r, z);
        z = 1'b0;
      end else begin
        res(ops[idx], q, r, z);
        dn = 1'b1;
      end
    end
    uo  = uio_in[5] ? {z, 3'b000, r} : q;
    uio = {dn, bsy, 6'b00_0000};
  endfunction

  function automatic void check(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%02h want=%02h cyc=%0d", nm, act, exp, cyc);
    end
  endfunction

  // per-cycle comparison against the model
  always @(negedge clk) begin
    logic [7:0] eu, eio;
    if (uio_out[6]) busy_cnt <= busy_cnt + 1;
    if (chk_en) begin
      expect_out(eu, eio);
      check("uo_out", uo_out, eu);
      check("uio_out", uio_out, eio);
      check("uio_oe", uio_oe, 8'hC0);
    end
  end

  task automatic tick(int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  // raise start; the model records the op if it will be accepted
  task automatic rise();
    int c;
    uio_in[4] = 1'b1;
    c = cyc + 4;
    if (ops.size() == 0 || c > ops[$].c + lat(ops[$].d)) begin
      ops.push_back('{c, int'(ui_in), int'(uio_in[3:0])});
      if (ops.size() > 3) void'(ops.pop_front());
    end
  endtask

  task automatic run_op(int n, int d, bit rsel);
    int tgt;
    ui_in = 8'(n);
    uio_in[3:0] = 4'(d);
    busy_cnt = 0;
    rise();
    tgt = ops[$].c + lat(ops[$].d) + 1;
    tick(2);
    uio_in[4] = 1'b0;
    while (cyc < tgt) begin
      if (rsel) uio_in[5] = 1'($urandom);
      tick(1);
    end
  endtask

  task automatic read_res(string nm, logic [7:0] eq, logic [7:0] ers);
    uio_in[5] = 1'b0;
    #1 check({nm, "_q"}, uo_out, eq);
    uio_in[5] = 1'b1;
    #1 check({nm, "_r"}, uo_out, ers);
    check({nm, "_done"}, uio_out, 8'h80);
    uio_in[5] = 1'b0;
  endtask

  initial begin
    int c0;
    #1 rst_n = 1'b0;
    #2 check("rst_uo0", uo_out, 8'h00);
    uio_in[5] = 1'b1;
    #1 check("rst_uo1", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hC0);
    uio_in[5] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick(3);

    run_op(200, 7, 0);
    check("busy_len", 8'(busy_cnt), 8'd8);
    read_res("200_7", 8'h1C, 8'h04);

    run_op(255, 1, 1);
    read_res("255_1", 8'hFF, 8'h00);
    run_op(225, 15, 1);
    read_res("225_15", 8'h0F, 8'h00);
    run_op(5, 9, 1);
    read_res("5_9", 8'h00, 8'h05);

    run_op(77, 0, 0);
    check("dbz_busy", 8'(busy_cnt), 8'd0);
    read_res("77_0", 8'hFF, 8'h80);

    // start re-raised mid-run, then held high
    ui_in = 8'd100;
    uio_in[3:0] = 4'd3;
    rise();
    c0 = ops[$].c;
    tick(2);
    uio_in[4] = 1'b0;
    tick(2);
    rise();
    tick(c0 + 20 - cyc);
    read_res("100_3", 8'h21, 8'h01);
    uio_in[4] = 1'b0;
    tick(3);

    // reset in the middle of an operation
    ui_in = 8'd200;
    uio_in[3:0] = 4'd7;
    rise();
    c0 = ops[$].c;
    tick(2);
    uio_in[4] = 1'b0;
    tick(c0 + 4 - cyc);
    rst_n = 1'b0;
    ops.delete();
    #1 check("mid_rst_uo0", uo_out, 8'h00);
    check("mid_rst_uio", uio_out, 8'h00);
    uio_in[5] = 1'b1;
    #1 check("mid_rst_uo1", uo_out, 8'h00);
    uio_in[5] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    run_op(200, 7, 0);
    read_res("post_rst", 8'h1C, 8'h04);

    // random overlapping starts, including D=0 and mid-run rises
    for (int i = 0; i < 300; i++) begin
      ui_in = 8'($urandom);
      uio_in[3:0] = 4'($urandom_range(0, 15));
      uio_in[5] = 1'($urandom);
      rise();
      tick($urandom_range(1, 3));
      uio_in[4] = 1'b0;
      uio_in[5] = 1'($urandom);
      tick($urandom_range(3, 12));
    end
    tick(20);

    // exhaustive sweep of non-zero divisors
    for (int n = 0; n < 256; n++)
      for (int d = 1; d < 16; d++)
        run_op(n, d, 1);

    tick(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_c13_seq_divider.md
# tt_um_c13_seq_divider

Sequential restoring divider: the inverse operation of the team's 4×4 array multiplier. It takes an 8-bit dividend (e.g. a multiplier product) and a 4-bit divisor, and returns an 8-bit quotient and a 4-bit remainder. It produces one quotient bit per clock under a start/busy/done handshake. It is a standalone Tiny Tapeout user top-level in the same tile family as the multiplier.

## Interface
- No parameters (widths fixed: dividend 8, divisor 4).
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low; clears all state.
- ena  input  1  always high when powered; unused.
- ui_in  input  8  dividend N[7:0].
- uio_in  input  8  [3:0] divisor D, [4] start (async level), [5] result select (0 = quotient, 1 = remainder/flags), [7:6] unused.
- uo_out  output  8  sel=0: quotient Q[7:0]; sel=1: {dbz, 3'b000, R[3:0]}.
- uio_out  output  8  [6] busy, [7] done, [5:0] driven 0.
- uio_oe  output  8  constant 8'b1100_0000.

## Operation
- Start path: uio_in[4] passes through a 2-flop synchroniser, then a third flop for rising-edge detect. The start pulse (start_p) is high for one cycle per rising edge.
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE or DONE, start_p=1 (capture edge):
  - Latch N into the shift register A and D into the divisor register.
  - Clear the partial remainder P (4b) and the step counter (3b).
  - Clear done and dbz.
  - If D≠0: set busy and go to RUN.
  - If D=0: go to DONE on the next edge.
- RUN, each edge:
  - T = {P, A[7]} (5b).
  - If T ≥ {1'b0, D}: P ← (T−D)[3:0], A ← {A[6:0],1}.
  - Else: P ← T[3:0], A ← {A[6:0],0}.
  - Counter increments. After the 8th step (counter was 7), go to DONE.
- Entering DONE:
  - Q_out ← A, R_out ← P; busy ← 0, done ← 1.
  - For the D=0 path instead: Q_out ← 8'hFF, R_out ← 4'h0, dbz ← 1.
- DONE holds the result until the next start_p. There is no auto-return to IDLE.
- start_p in RUN is ignored (no queueing, no restart).
- Q_out/R_out/dbz change only on entry to DONE. A capture clears done/dbz but leaves Q_out/R_out showing the previous result until the new completion.
- The select bit uio_in[5] is a combinational mux onto uo_out, unsynchronised. Host holds it static while reading.
- Invariant: P < D after every RUN step. The 4b remainder never overflows. The final result satisfies Q·D + R = N, R < D.

## Timing
- Reset (async assert) values: FSM=IDLE, sync flops 0, busy=0, done=0, dbz=0, Q_out=0, R_out=0.
  - Hence uo_out=0x00 (either sel), uio_out=0x00.
- Start latency: a pin rise ahead of edge k gives start_p high after edge k+2; the capture edge is k+3.
- N and D must be stable from start rise through the capture edge (≥4 cycles).
- Capture at edge C (D≠0): busy high after C; RUN steps on edges C+1…C+8; done=1, busy=0, result valid after edge C+8.
- Capture at edge C (D=0): done=1, dbz=1 after C+1; busy never asserts.
- busy and done are never high together; both are registered outputs.
- rst_n low mid-RUN: immediate return to reset values; no partial result is retained.
- Start held high continuously: one operation only. A new operation requires a low-then-high on uio_in[4].

## Test plan
- After reset: uo_out=0x00, uio_out=0x00, uio_oe=0xC0.
- N=200, D=7, pulse start:
  - busy for exactly 8 cycles.
  - Then sel=0 → uo_out=28 (0x1C); sel=1 → uo_out=0x04; done=1.
- Edge operands and full sweep:
  - N=255, D=1 → Q=0xFF, R=0.
  - N=225, D=15 → Q=15, R=0.
  - N=5, D=9 → Q=0, R=5.
  - Sweep all 256×15 pairs (D≠0) against the Q·D+R=N, R<D reference.
- N=77, D=0 → done after 1 cycle, busy never high, Q=0xFF, sel=1 → uo_out=0x80.
- Start during busy: issue a start rise mid-RUN (N=100, D=3) → ignored; result Q=33, R=1 after 8 steps. Start held high → no second operation.
- Reset mid-RUN: assert rst_n low at step 4 of N=200, D=7 → outputs 0x00 immediately. A new start then completes normally.
